// File: rtl/fft_bfly_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_bfly_scheduler_if
// Purpose  : Butterfly descriptor bus (valid/ready) between scheduler and datapath.
// Revision : 1.0
// ============================================================================
interface fft_bfly_scheduler_if #(
    parameter int LOG2N = 3
);
    logic             issue_valid;
    logic             issue_ready;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic [1:0]       prec_sel;
    logic [3:0]       stage;

    modport master (
        output issue_valid, addr_a, addr_b, tw_idx, prec_sel, stage,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, addr_a, addr_b, tw_idx, prec_sel, stage,
        output issue_ready
    );
endinterface
`default_nettype wire

// File: rtl/fft_bfly_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fft_bfly_scheduler
// Purpose  : Radix-2 DIT in-place FFT butterfly sequencer with per-stage precision.
// Revision : 1.0
// ============================================================================
module fft_bfly_scheduler #(
    parameter int LOG2N        = 3,
    parameter int DRAIN_CYCLES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic [LOG2N-1:0] cfg_mult_prec,
    input  wire logic [LOG2N-1:0] cfg_add_prec,
    fft_bfly_scheduler_if.master  bfly,
    output logic                  busy,
    output logic                  done
);
    localparam int              KW         = LOG2N - 1;
    localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [KW-1:0]   K_LAST     = '1;
    localparam logic [3:0]      S_LAST     = 4'(LOG2N - 1);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [LOG2N-1:0] mult_q, mult_d;
    logic [LOG2N-1:0] add_q, add_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             handshake;
    logic             stage_end;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        k_d       = k_q;
        drain_d   = drain_q;
        mult_d    = mult_q;
        add_d     = add_q;
        stage_end = 1'b0;
        handshake = valid_q & bfly.issue_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mult_d  = cfg_mult_prec;
                    add_d   = cfg_add_prec;
                    s_d     = '0;
                    k_d     = '0;
                    drain_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (DRAIN_CYCLES == 0) begin
                            stage_end = 1'b1;
                        end else begin
                            drain_d = '0;
                            state_d = DRAIN;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    stage_end = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stage_end) begin
            if (s_q < S_LAST) begin
                s_d     = s_q + 4'd1;
                state_d = ISSUE;
            end else begin
                state_d = DONE;
            end
        end

        // Status outputs are registered from the next state so they align with it.
        valid_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
            mult_q  <= '0;
            add_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            mult_q  <= mult_d;
            add_q   <= add_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Descriptor: j = k mod 2^s, group g = k >> s, addr_a = (g << (s+1)) | j.
    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] addr_a_w;
    logic [KW-1:0]    j_w;
    logic [KW-1:0]    tw_w;
    logic [LOG2N-1:0] mult_sh;
    logic [LOG2N-1:0] add_sh;

    always_comb begin
        k_ext    = LOG2N'(k_q);
        half     = LOG2N'(1) << s_q;
        mask     = half - LOG2N'(1);
        addr_a_w = ((k_ext >> s_q) << (s_q + 4'd1)) | (k_ext & mask);
        j_w      = KW'(k_ext & mask);
        tw_w     = j_w << (S_LAST - s_q);
        mult_sh  = mult_q >> s_q;
        add_sh   = add_q >> s_q;
    end

    // Descriptor fields read zero whenever the scheduler is idle, including after reset.
    assign bfly.issue_valid = valid_q;
    assign bfly.addr_a      = busy_q ? addr_a_w : '0;
    assign bfly.addr_b      = busy_q ? (addr_a_w | half) : '0;
    assign bfly.tw_idx      = busy_q ? tw_w : '0;
    assign bfly.prec_sel    = busy_q ? {add_sh[0], mult_sh[0]} : 2'b00;
    assign bfly.stage       = busy_q ? s_q : 4'd0;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bfly_scheduler
// Purpose  : Scoreboard bench for fft_bfly_scheduler (LOG2N=3/DRAIN=2 and LOG2N=2/DRAIN=0).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fft_bfly_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, start1;
    logic [2:0] mult0, add0;
    logic [1:0] mult1, add1;
    logic       busy0, done0, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int exp_done0 = -1;
    int exp_done1 = -1;
    int sc;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic        stalled0 = 1'b0;
    logic [63:0] held0;

    fft_bfly_scheduler_if #(.LOG2N(3)) bus0();
    fft_bfly_scheduler_if #(.LOG2N(2)) bus1();

    fft_bfly_scheduler #(.LOG2N(3), .DRAIN_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .cfg_mult_prec(mult0), .cfg_add_prec(add0),
        .bfly(bus0), .busy(busy0), .done(done0)
    );

    fft_bfly_scheduler #(.LOG2N(2), .DRAIN_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .cfg_mult_prec(mult1), .cfg_add_prec(add1),
        .bfly(bus1), .busy(busy1), .done(done1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(int a, int b, int tw, int prec, int st);
        return {24'd0, 8'(st), 8'(prec), 8'(tw), 8'(b), 8'(a)};
    endfunction

    // Reference order: for each stage, walk the groups of 2*half and pair j with j+half.
    task automatic push_run(int which, int lg, logic [14:0] mult, logic [14:0] add);
        int n;
        n = 1 << lg;
        for (int s = 0; s < lg; s++) begin
            int half;
            int prec;
            half = 1 << s;
            prec = {30'd0, add[s], mult[s]};
            for (int base = 0; base < n; base += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    logic [63:0] d;
                    d = pack(base + j, base + j + half, j * (n / (2 * half)), prec, s);
                    if (which == 0) q0.push_back(d);
                    else            q1.push_back(d);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_done(int which, int target, int budget);
        int n;
        n = 0;
        while (((which == 0) ? done_cnt0 : done_cnt1) < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_seen", (which == 0) ? done_cnt0 : done_cnt1, target);
    endtask

    task automatic check_zero0(string tag);
        chk({tag, "_valid"}, 64'(bus0.issue_valid), 0);
        chk({tag, "_busy"},  64'(busy0), 0);
        chk({tag, "_done"},  64'(done0), 0);
        chk({tag, "_desc"},  pack(bus0.addr_a, bus0.addr_b, bus0.tw_idx, bus0.prec_sel, bus0.stage), 0);
    endtask

    // Monitor for the LOG2N=3 instance: scoreboard, hold-while-stalled and done timing.
    always @(negedge clk) begin
        logic [63:0] cur;
        cur = pack(bus0.addr_a, bus0.addr_b, bus0.tw_idx, bus0.prec_sel, bus0.stage);
        if (bus0.issue_valid) begin
            if (stalled0) chk("hold0", cur, held0);
            if (bus0.issue_ready) begin
                stalled0 = 1'b0;
                if (q0.size() == 0) chk("extra_issue0", cur, '1);
                else                chk("desc0", cur, q0.pop_front());
            end else begin
                stalled0 = 1'b1;
                held0    = cur;
            end
        end else begin
            if (stalled0) chk("valid_drop0", 64'(bus0.issue_valid), 1);
            stalled0 = 1'b0;
        end
        if (done0) begin
            done_cnt0++;
            chk("done_cyc0", cyc, exp_done0);
        end
    end

    always @(negedge clk) begin
        logic [63:0] cur;
        cur = pack(bus1.addr_a, bus1.addr_b, bus1.tw_idx, bus1.prec_sel, bus1.stage);
        if (bus1.issue_valid && bus1.issue_ready) begin
            if (q1.size() == 0) chk("extra_issue1", cur, '1);
            else                chk("desc1", cur, q1.pop_front());
        end
        if (done1) begin
            done_cnt1++;
            chk("done_cyc1", cyc, exp_done1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        mult0 = '0; add0 = '0; mult1 = '0; add1 = '0;
        bus0.issue_ready = 1'b1;
        bus1.issue_ready = 1'b1;
        repeat (2) tick();
        check_zero0("rst");
        chk("rst1_busy",  64'(busy1), 0);
        chk("rst1_addrb", 64'(bus1.addr_b), 0);
        rst_n = 1'b1;
        tick();

        // Full run with precision schedule, cfg change and ignored starts.
        mult0 = 3'b100; add0 = 3'b110;
        push_run(0, 3, 15'(mult0), 15'(add0));
        sc = cyc; exp_done0 = sc + 19;
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("busy_rise",  64'(busy0), 1);
        chk("valid_rise", 64'(bus0.issue_valid), 1);
        goto_cyc(sc + 3);
        start0 = 1'b1; mult0 = 3'b011; add0 = 3'b001;
        tick(); start0 = 1'b0;
        goto_cyc(sc + 19);
        chk("done_pulse", 64'(done0), 1);
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("busy_fall", 64'(busy0), 0);
        goto_cyc(sc + 24);
        chk("idle_after", 64'(bus0.issue_valid), 0);
        chk("done_cnt_a", done_cnt0, 1);
        chk("q0_empty_a", q0.size(), 0);

        // Back-pressure on the second stage-1 descriptor.
        push_run(0, 3, 15'(mult0), 15'(add0));
        sc = cyc; exp_done0 = sc + 22;
        start0 = 1'b1; tick(); start0 = 1'b0;
        goto_cyc(sc + 8);
        bus0.issue_ready = 1'b0;
        goto_cyc(sc + 9);
        chk("stall_desc", pack(bus0.addr_a, bus0.addr_b, bus0.tw_idx, bus0.prec_sel, bus0.stage),
            pack(1, 3, 2, {30'd0, add0[1], mult0[1]}, 1));
        goto_cyc(sc + 11);
        bus0.issue_ready = 1'b1;
        wait_done(0, 2, 60);
        goto_cyc(exp_done0 + 2);
        chk("q0_empty_b", q0.size(), 0);

        // Reset mid stage 1, then a fresh transform.
        push_run(0, 3, 15'(mult0), 15'(add0));
        sc = cyc; exp_done0 = -1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        goto_cyc(sc + 8);
        rst_n = 1'b0;
        #1;
        check_zero0("midrst");
        q0.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        mult0 = 3'b010; add0 = 3'b101;
        push_run(0, 3, 15'(mult0), 15'(add0));
        sc = cyc; exp_done0 = sc + 19;
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("restart_first", pack(bus0.addr_a, bus0.addr_b, bus0.tw_idx, bus0.prec_sel, bus0.stage),
            pack(0, 1, 0, {30'd0, add0[0], mult0[0]}, 0));
        wait_done(0, 3, 60);
        goto_cyc(exp_done0 + 2);
        chk("q0_empty_d", q0.size(), 0);

        // LOG2N=2 with no drain window.
        mult1 = 2'b01; add1 = 2'b10;
        push_run(1, 2, 15'(mult1), 15'(add1));
        sc = cyc; exp_done1 = sc + 5;
        start1 = 1'b1; tick(); start1 = 1'b0;
        wait_done(1, 1, 30);
        goto_cyc(sc + 6);
        chk("busy1_fall", 64'(busy1), 0);
        chk("q1_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fft_bfly_scheduler.md
# fft_bfly_scheduler

Sequences one radix-2 decimation-in-time, in-place FFT over a shared butterfly datapath, with run-time mixed precision. For every butterfly it issues the operand address pair, the twiddle index and the precision mode, using a valid/ready handshake. Between stages it inserts a fixed drain window so that pipelined write-back settles before the next stage reads. It sits between the FFT data/twiddle memories and the bank of precision-specific butterfly instances, and it drives the mux that selects which instance is used.

## Interface
- LOG2N, default 3: log2 of the FFT size, legal range 2..15; N = 2^LOG2N.
- DRAIN_CYCLES, default 2: idle cycles after the last issue of each stage, covering butterfly and write-back latency; 0 is legal.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; honoured only in IDLE.
- cfg_mult_prec  in  LOG2N  per-stage multiply precision; bit s is stage s; 0 = FP4, 1 = FP8.
- cfg_add_prec  in  LOG2N  per-stage add precision; bit s is stage s; 0 = FP4, 1 = FP8.
- issue_valid  out  1  a butterfly descriptor is presented.
- issue_ready  in  1  the datapath accepts the descriptor.
- addr_a  out  LOG2N  upper-leg operand address.
- addr_b  out  LOG2N  lower-leg operand address.
- tw_idx  out  LOG2N-1  twiddle index k, meaning W_N^k.
- prec_sel  out  2  {add_prec, mult_prec} for the current stage.
- stage  out  4  current stage number.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - When start=1, latch cfg_mult_prec and cfg_add_prec, clear the stage counter s and butterfly counter k, then go to ISSUE.
  - Changes on the cfg inputs after the latch have no effect on the running transform.
- ISSUE:
  - issue_valid = 1.
  - A handshake is issue_valid & issue_ready. On a handshake, k increments.
  - If k = N/2-1 at the handshake, k clears and the FSM goes to DRAIN, or directly to the end-of-stage decision when DRAIN_CYCLES=0.
- Descriptor, combinational from the registered s and k:
  - half = 2^s; j = k mod half; g = k >> s.
  - addr_a = (g << (s+1)) | j; addr_b = addr_a + half.
  - tw_idx = j << (LOG2N-1-s).
  - prec_sel = {add_prec[s], mult_prec[s]}; stage = s.
- DRAIN:
  - Count DRAIN_CYCLES cycles with issue_valid=0.
  - End-of-stage decision: if s < LOG2N-1, increment s and return to ISSUE; otherwise go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored, including in the DONE cycle.
- Handshake rules:
  - While issue_valid=1 and issue_ready=0, addr_a, addr_b, tw_idx, prec_sel and stage are held stable.
  - issue_valid never drops without a handshake.
- Reset, at any time including mid-transform:
  - State goes to IDLE; all counters and latched cfg clear.
  - issue_valid, busy and done are 0; addr_a, addr_b, tw_idx, prec_sel and stage are 0.
  - No partial-stage resumption.

## Timing
- Each butterfly takes 1 cycle when ready is held high; a ready stall adds 1 cycle per cycle stalled.
- start sampled at edge t0: busy=1 and issue_valid=1 from t0+1.
- Stage length with ready held high is N/2 + DRAIN_CYCLES cycles.
- done is asserted at t0 + 1 + LOG2N*(N/2 + DRAIN_CYCLES); busy falls one cycle later.
- A new start is accepted from the first IDLE cycle after done, giving back-to-back transforms with a single idle cycle between them.

## Test plan
- Full run: LOG2N=3, DRAIN_CYCLES=2, ready held high, start at t0 → issue sequence:
  - stage 0: (0,1,w0) (2,3,w0) (4,5,w0) (6,7,w0)
  - stage 1: (0,2,w0) (1,3,w2) (4,6,w0) (5,7,w2)
  - stage 2: (0,4,w0) (1,5,w1) (2,6,w2) (3,7,w3)
  - issue_valid=0 for 2 cycles after each stage; done at t0+19; busy=0 at t0+20.
- Precision schedule: cfg_mult_prec=3'b100, cfg_add_prec=3'b110 → prec_sel reads 0, 2, 3 for stages 0, 1, 2. Changing cfg mid-run has no effect.
- Back-pressure: ready low for 3 cycles on the second stage-1 descriptor → (1,3,w2) held stable; done is delayed by exactly 3 cycles versus the full-run case.
- start pulsed during ISSUE and during DONE → ignored; exactly one transform and one done pulse.
- rst_n asserted mid stage 1 → all outputs 0 immediately. A fresh start after release restarts at stage 0 with (0,1,w0).
- DRAIN_CYCLES=0, LOG2N=2 → issue sequence (0,1,w0) (2,3,w0) (0,2,w0) (1,3,w1) with no gap; done at t0+5.
